microseq_ctrl: RTL and testbench

Next-address control unit that drives a cascade of 4-bit microprogram sequencer slices (AW/4 slices). It holds the microinstruction pipeline register fed by the control store and decodes its next-address opcode, with a selected condition, into the slice control lines: s0, s1, zero, cin, re, fe and pup. It also supplies the slice D and R inputs, and owns a loop counter and a stack-depth tracker with a sticky error flag.

---
 rtl/microseq_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_microseq_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/microseq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : microseq_ctrl
// Description : Next-address control for a cascade of 4-bit microprogram
//               sequencer slices (AW/4 slices). Holds the microinstruction
//               pipeline register, decodes the next-address opcode plus a
//               selected condition into the slice control lines, supplies
//               the slice D/R inputs, and owns a loop counter and a
//               stack-depth tracker with a sticky overflow/underflow flag.
//
// Parameters  : AW  microaddress width (multiple of 4, one slice per nibble)
//               CW  loop counter width (must not exceed AW)
//
// Ports       : clock    rising-edge clock shared with the slices
//               reset    synchronous, active-high; dominates stall
//               stall    holds pipeline, counter, depth and microaddress
//               op_in    next-address opcode from the control store
//               ba_in    branch/constant field from the control store
//               csel_in  condition select from the control store
//               cpol_in  condition polarity (1 inverts)
//               cond_in  condition inputs (bit 0 tied high externally)
//               s0, s1   slice source select: 00 PC, 01 AR, 10 stack, 11 D
//               zero     active-low force of slice output address to 0
//               cin      incrementer carry into the least-significant slice
//               re       active-low AR load
//               fe       active-low stack enable
//               pup      1 = push, 0 = pop (meaningful when fe = 0)
//               d_out    slice D inputs (pipelined ba)
//               r_out    slice R inputs (pipelined ba)
//               cnt      loop counter value
//               stk_err  sticky stack overflow/underflow flag
//
// Revision    : 1.0  initial release
// ============================================================================
module microseq_ctrl #(
  parameter int AW = 12,
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          stall,
  input  logic [3:0]    op_in,
  input  logic [AW-1:0] ba_in,
  input  logic [2:0]    csel_in,
  input  logic          cpol_in,
  input  logic [7:0]    cond_in,
  output logic          s0,
  output logic          s1,
  output logic          zero,
  output logic          cin,
  output logic          re,
  output logic          fe,
  output logic          pup,
  output logic [AW-1:0] d_out,
  output logic [AW-1:0] r_out,
  output logic [CW-1:0] cnt,
  output logic          stk_err
);

  // Next-address opcodes
  localparam logic [3:0] c_OP_JZ   = 4'd0;
  localparam logic [3:0] c_OP_CONT = 4'd1;
  localparam logic [3:0] c_OP_JMP  = 4'd2;
  localparam logic [3:0] c_OP_CJP  = 4'd3;
  localparam logic [3:0] c_OP_JSR  = 4'd4;
  localparam logic [3:0] c_OP_CJS  = 4'd5;
  localparam logic [3:0] c_OP_RTN  = 4'd6;
  localparam logic [3:0] c_OP_CRTN = 4'd7;
  localparam logic [3:0] c_OP_LDCT = 4'd8;
  localparam logic [3:0] c_OP_RPCT = 4'd9;
  localparam logic [3:0] c_OP_LDAR = 4'd10;
  localparam logic [3:0] c_OP_JAR  = 4'd11;
  localparam logic [3:0] c_OP_CJAR = 4'd12;
  localparam logic [3:0] c_OP_PUSH = 4'd13;
  localparam logic [3:0] c_OP_POP  = 4'd14;
  localparam logic [3:0] c_OP_WAIT = 4'd15;

  // Slice source select encodings {s1, s0}
  localparam logic [1:0] c_SRC_PC  = 2'b00;
  localparam logic [1:0] c_SRC_AR  = 2'b01;
  localparam logic [1:0] c_SRC_STK = 2'b10;
  localparam logic [1:0] c_SRC_D   = 2'b11;

  // Slice stack depth (4 entries)
  localparam logic [2:0] c_DEPTH_MAX = 3'd4;

  // Pipeline register and state
  logic [3:0]    r_op;
  logic [AW-1:0] r_ba;
  logic [2:0]    r_csel;
  logic          r_cpol;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_depth;
  logic          r_err;

  // Decode results
  logic          w_cc;
  logic [1:0]    w_src;
  logic          w_zero;
  logic          w_cin;
  logic          w_re;
  logic          w_fe;
  logic          w_pup;
  logic          w_ld_cnt;
  logic          w_dec_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_cc = cond_in[r_csel] ^ r_cpol;

  always_comb begin
    w_src     = c_SRC_PC;
    w_zero    = 1'b1;
    w_cin     = 1'b1;
    w_re      = 1'b1;
    w_fe      = 1'b1;
    w_pup     = 1'b0;
    w_ld_cnt  = 1'b0;
    w_dec_cnt = 1'b0;
    if (stall) begin
      // Recirculate: PC source with no increment keeps the address steady.
      w_cin = 1'b0;
    end else begin
      case (r_op)
        c_OP_JZ:   w_zero = 1'b0;
        c_OP_CONT: ;
        c_OP_JMP:  w_src = c_SRC_D;
        c_OP_CJP:  if (w_cc) w_src = c_SRC_D;
        c_OP_JSR: begin
          w_src = c_SRC_D;
          w_fe  = 1'b0;
          w_pup = 1'b1;
        end
        c_OP_CJS: begin
          if (w_cc) begin
            w_src = c_SRC_D;
            w_fe  = 1'b0;
            w_pup = 1'b1;
          end
        end
        c_OP_RTN: begin
          w_src = c_SRC_STK;
          w_fe  = 1'b0;
        end
        c_OP_CRTN: begin
          if (w_cc) begin
            w_src = c_SRC_STK;
            w_fe  = 1'b0;
          end
        end
        c_OP_LDCT: w_ld_cnt = 1'b1;
        c_OP_RPCT: begin
          // Loop back to D until the counter is exhausted, then fall through.
          if (r_cnt != '0) begin
            w_src     = c_SRC_D;
            w_dec_cnt = 1'b1;
          end
        end
        c_OP_LDAR: w_re = 1'b0;
        c_OP_JAR:  w_src = c_SRC_AR;
        c_OP_CJAR: if (w_cc) w_src = c_SRC_AR;
        c_OP_PUSH: begin
          w_fe  = 1'b0;
          w_pup = 1'b1;
        end
        c_OP_POP:  w_fe = 1'b0;
        c_OP_WAIT: if (!w_cc) w_cin = 1'b0;
        default: ;
      endcase
    end
  end

  assign w_push = ~w_fe & w_pup;
  assign w_pop  = ~w_fe & ~w_pup;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_op    <= c_OP_JZ;
      r_ba    <= '0;
      r_csel  <= 3'd0;
      r_cpol  <= 1'b0;
      r_cnt   <= '0;
      r_depth <= 3'd0;
      r_err   <= 1'b0;
    end else if (!stall) begin
      r_op   <= op_in;
      r_ba   <= ba_in;
      r_csel <= csel_in;
      r_cpol <= cpol_in;

      if (w_ld_cnt) begin
        r_cnt <= r_ba[CW-1:0];
      end else if (w_dec_cnt) begin
        r_cnt <= r_cnt - 1'b1;
      end

      // Depth saturates at both ends; hitting either end latches the error.
      if (w_push) begin
        if (r_depth == c_DEPTH_MAX) begin
          r_err <= 1'b1;
        end else begin
          r_depth <= r_depth + 3'd1;
        end
      end else if (w_pop) begin
        if (r_depth == 3'd0) begin
          r_err <= 1'b1;
        end else begin
          r_depth <= r_depth - 3'd1;
        end
      end
    end
  end

  assign s0      = w_src[0];
  assign s1      = w_src[1];
  assign zero    = w_zero;
  assign cin     = w_cin;
  assign re      = w_re;
  assign fe      = w_fe;
  assign pup     = w_pup;
  assign d_out   = r_ba;
  assign r_out   = r_ba;
  assign cnt     = r_cnt;
  assign stk_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_microseq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_microseq_ctrl
// Description : Self-checking bench for microseq_ctrl. Directed instruction
//               vectors are issued one per cycle; each vector carries the
//               hand-computed outputs for the instruction already sitting in
//               the pipeline. Those expectations go into a queue that a
//               separate monitor drains mid-cycle. A small slice model turns
//               the control lines into the microaddress so address sequences
//               can be checked too.
// Revision    : 1.0  initial release
// ============================================================================
module tb_microseq_ctrl;

  localparam int AW = 12;
  localparam int CW = 8;
  localparam int X  = -1;   // don't-care marker in expectation vectors

  localparam logic [3:0] OP_JZ   = 4'd0;
  localparam logic [3:0] OP_CONT = 4'd1;
  localparam logic [3:0] OP_CJP  = 4'd3;
  localparam logic [3:0] OP_JSR  = 4'd4;
  localparam logic [3:0] OP_RTN  = 4'd6;
  localparam logic [3:0] OP_LDCT = 4'd8;
  localparam logic [3:0] OP_RPCT = 4'd9;
  localparam logic [3:0] OP_LDAR = 4'd10;
  localparam logic [3:0] OP_JAR  = 4'd11;
  localparam logic [3:0] OP_POP  = 4'd14;
  localparam logic [3:0] OP_WAIT = 4'd15;

  logic          clock;
  logic          reset;
  logic          stall;
  logic [3:0]    op_in;
  logic [AW-1:0] ba_in;
  logic [2:0]    csel_in;
  logic          cpol_in;
  logic [7:0]    cond_in;
  logic          s0, s1, zero, cin, re, fe, pup;
  logic [AW-1:0] d_out, r_out;
  logic [CW-1:0] cnt;
  logic          stk_err;

  microseq_ctrl #(.AW(AW), .CW(CW)) dut (
    .clock   (clock),
    .reset   (reset),
    .stall   (stall),
    .op_in   (op_in),
    .ba_in   (ba_in),
    .csel_in (csel_in),
    .cpol_in (cpol_in),
    .cond_in (cond_in),
    .s0      (s0),
    .s1      (s1),
    .zero    (zero),
    .cin     (cin),
    .re      (re),
    .fe      (fe),
    .pup     (pup),
    .d_out   (d_out),
    .r_out   (r_out),
    .cnt     (cnt),
    .stk_err (stk_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // --------------------------------------------------------------------------
  // Slice cascade model: microPC, AR and a 4-deep stack.
  // --------------------------------------------------------------------------
  logic [AW-1:0] m_pc, m_ar, m_y, m_tos;
  logic [AW-1:0] m_stk [4];
  int            m_sp;

  always_comb begin
    m_tos = (m_sp > 0) ? m_stk[m_sp-1] : '0;
    case ({s1, s0})
      2'b00:   m_y = m_pc;
      2'b01:   m_y = m_ar;
      2'b10:   m_y = m_tos;
      default: m_y = d_out;
    endcase
    if (!zero) m_y = '0;
  end

  always @(posedge clock) begin
    if (reset) begin
      m_pc <= '0;
      m_sp <= 0;
    end else begin
      if (!re) m_ar <= r_out;
      if (!fe) begin
        if (pup) begin
          if (m_sp < 4) begin
            m_stk[m_sp] <= m_pc;
            m_sp        <= m_sp + 1;
          end
        end else if (m_sp > 0) begin
          m_sp <= m_sp - 1;
        end
      end
      m_pc <= m_y + {{(AW-1){1'b0}}, cin};
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    int id;
    int s, zero, cin, re, fe, pup, cnt, err, y, d;
  } exp_t;

  exp_t q_exp[$];
  exp_t m_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step    = 0;

  function automatic exp_t ex(int s, int zr, int ci, int r, int f, int p,
                              int c, int er, int y, int d);
    exp_t e;
    e.id = 0;
    e.s = s; e.zero = zr; e.cin = ci; e.re = r; e.fe = f; e.pup = p;
    e.cnt = c; e.err = er; e.y = y; e.d = d;
    return e;
  endfunction

  task automatic chk(int id, string nm, int act, int expv);
    if (expv < 0) return;
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL step %0d %s: got 0x%0h, expected 0x%0h", id, nm, act, expv);
    end
  endtask

  always @(negedge clock) begin
    if (q_exp.size() > 0) begin
      m_e = q_exp.pop_front();
      chk(m_e.id, "s",       int'({s1, s0}), m_e.s);
      chk(m_e.id, "zero",    int'(zero),     m_e.zero);
      chk(m_e.id, "cin",     int'(cin),      m_e.cin);
      chk(m_e.id, "re",      int'(re),       m_e.re);
      chk(m_e.id, "fe",      int'(fe),       m_e.fe);
      chk(m_e.id, "pup",     int'(pup),      m_e.pup);
      chk(m_e.id, "cnt",     int'(cnt),      m_e.cnt);
      chk(m_e.id, "stk_err", int'(stk_err),  m_e.err);
      chk(m_e.id, "addr",    int'(m_y),      m_e.y);
      chk(m_e.id, "d_out",   int'(d_out),    m_e.d);
      if (m_e.d >= 0) chk(m_e.id, "r_out", int'(r_out), m_e.d);
    end
  end

  // Called at posedge+1: drives the next instruction plus this cycle's
  // cond/stall, and queues the outputs expected for the current pipeline.
  task automatic cyc(logic [3:0] op, int ba, int csel, int cpol,
                     logic [7:0] cond, logic stl, exp_t e);
    op_in   = op;
    ba_in   = AW'(ba);
    csel_in = 3'(csel);
    cpol_in = cpol[0];
    cond_in = cond;
    stall   = stl;
    step++;
    e.id = step;
    q_exp.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(logic stl);
    reset   = 1'b1;
    stall   = stl;
    op_in   = OP_CONT;
    cond_in = 8'h01;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; op_in = OP_CONT; ba_in = '0;
    csel_in = '0; cpol_in = 1'b0; cond_in = 8'h01;
    @(posedge clock);
    #1;
    do_reset(1'b0);

    //   issue: op      ba     csel cpol cond   stall  expect: s zr ci re fe pu cnt er addr   d
    // Reset then CONT x3: addresses 0,1,2,3
    cyc(OP_CONT, 0,     0, 0, 8'h01, 0, ex(0, 0, 1, 1, 1, 0, 0, 0, 0,     X));
    cyc(OP_CONT, 0,     0, 0, 8'h01, 0, ex(0, 1, 1, 1, 1, 0, 0, 0, 1,     X));
    cyc(OP_CONT, 0,     0, 0, 8'h01, 0, ex(0, 1, 1, 1, 1, 0, 0, 0, 2,     X));
    // LDCT 3 then RPCT loop
    cyc(OP_LDCT, 3,     0, 0, 8'h01, 0, ex(0, 1, 1, 1, 1, 0, 0, 0, 3,     X));
    cyc(OP_RPCT, 'h040, 0, 0, 8'h01, 0, ex(0, 1, 1, 1, 1, 0, 0, 0, 4,     X));
    cyc(OP_RPCT, 'h040, 0, 0, 8'h01, 0, ex(3, 1, 1, 1, 1, 0, 3, 0, 'h040, 'h040));
    cyc(OP_RPCT, 'h040, 0, 0, 8'h01, 0, ex(3, 1, 1, 1, 1, 0, 2, 0, 'h040, 'h040));
    cyc(OP_RPCT, 'h040, 0, 0, 8'h01, 0, ex(3, 1, 1, 1, 1, 0, 1, 0, 'h040, 'h040));
    // Fourth RPCT falls through with cnt held at 0
    cyc(OP_CJP,  'h123, 2, 0, 8'h01, 0, ex(0, 1, 1, 1, 1, 0, 0, 0, 'h041, 'h040));
    // CJP on cond_in[2], both polarities
    cyc(OP_CJP,  'h123, 2, 0, 8'h05, 0, ex(3, 1, 1, 1, 1, 0, 0, 0, 'h123, 'h123));
    cyc(OP_CJP,  'h123, 2, 1, 8'h01, 0, ex(0, 1, 1, 1, 1, 0, 0, 0, 'h124, 'h123));
    cyc(OP_CJP,  'h123, 2, 1, 8'h05, 0, ex(0, 1, 1, 1, 1, 0, 0, 0, 'h125, 'h123));
    cyc(OP_JSR,  'h200, 0, 0, 8'h01, 0, ex(3, 1, 1, 1, 1, 0, 0, 0, 'h123, 'h123));
    // Five JSRs: overflow on the fifth edge
    cyc(OP_JSR,  'h200, 0, 0, 8'h01, 0, ex(3, 1, 1, 1, 0, 1, 0, 0, 'h200, 'h200));
    cyc(OP_JSR,  'h200, 0, 0, 8'h01, 0, ex(3, 1, 1, 1, 0, 1, 0, 0, 'h200, 'h200));
    cyc(OP_JSR,  'h200, 0, 0, 8'h01, 0, ex(3, 1, 1, 1, 0, 1, 0, 0, 'h200, 'h200));
    cyc(OP_JSR,  'h200, 0, 0, 8'h01, 0, ex(3, 1, 1, 1, 0, 1, 0, 0, 'h200, 'h200));
    cyc(OP_POP,  0,     0, 0, 8'h01, 0, ex(3, 1, 1, 1, 0, 1, 0, 0, 'h200, 'h200));
    cyc(OP_POP,  0,     0, 0, 8'h01, 0, ex(0, 1, 1, 1, 0, 0, 0, 1, 'h201, X));
    cyc(OP_LDCT, 9,     0, 0, 8'h01, 0, ex(0, 1, 1, 1, 0, 0, 0, 1, 'h202, X));
    cyc(OP_CONT, 0,     0, 0, 8'h01, 0, ex(0, 1, 1, 1, 1, 0, 0, 1, 'h203, X));
    cyc(OP_CONT, 0,     0, 0, 8'h01, 0, ex(0, 1, 1, 1, 1, 0, 9, 1, 'h204, X));

    // Reset asserted together with stall: reset must still clear everything
    do_reset(1'b1);
    cyc(OP_RTN,  0,     0, 0, 8'h01, 0, ex(0, 0, 1, 1, 1, 0, 0, 0, 0,     X));
    // RTN at depth 0 underflows
    cyc(OP_CONT, 0,     0, 0, 8'h01, 0, ex(2, 1, 1, 1, 0, 0, 0, 0, X,     X));
    cyc(OP_CONT, 0,     0, 0, 8'h01, 0, ex(0, 1, 1, 1, 1, 0, 0, 1, X,     X));

    // WAIT on cond_in[3]: held four cycles, then advances
    do_reset(1'b0);
    cyc(OP_WAIT, 0,     3, 0, 8'h01, 0, ex(0, 0, 1, 1, 1, 0, 0, 0, 0,     X));
    cyc(OP_WAIT, 0,     3, 0, 8'h01, 0, ex(0, 1, 0, 1, 1, 0, 0, 0, 1,     X));
    cyc(OP_WAIT, 0,     3, 0, 8'h01, 0, ex(0, 1, 0, 1, 1, 0, 0, 0, 1,     X));
    cyc(OP_WAIT, 0,     3, 0, 8'h01, 0, ex(0, 1, 0, 1, 1, 0, 0, 0, 1,     X));
    cyc(OP_WAIT, 0,     3, 0, 8'h01, 0, ex(0, 1, 0, 1, 1, 0, 0, 0, 1,     X));
    cyc(OP_LDCT, 5,     3, 0, 8'h09, 0, ex(0, 1, 1, 1, 1, 0, 0, 0, 1,     X));
    // Stall for two cycles during RPCT with cnt = 5
    cyc(OP_RPCT, 'h0A0, 0, 0, 8'h01, 0, ex(0, 1, 1, 1, 1, 0, 0, 0, 2,     X));
    cyc(OP_JZ,   0,     0, 0, 8'h01, 1, ex(0, 1, 0, 1, 1, 0, 5, 0, 3,     X));
    cyc(OP_JZ,   0,     0, 0, 8'h01, 1, ex(0, 1, 0, 1, 1, 0, 5, 0, 3,     X));
    cyc(OP_RPCT, 'h0A0, 0, 0, 8'h01, 0, ex(3, 1, 1, 1, 1, 0, 5, 0, 'h0A0, 'h0A0));
    cyc(OP_LDAR, 'h055, 0, 0, 8'h01, 0, ex(3, 1, 1, 1, 1, 0, 4, 0, 'h0A0, 'h0A0));
    // LDAR then JAR through the slice AR
    cyc(OP_JAR,  0,     0, 0, 8'h01, 0, ex(0, 1, 1, 0, 1, 0, 3, 0, 'h0A1, 'h055));
    cyc(OP_CONT, 0,     0, 0, 8'h01, 0, ex(1, 1, 1, 1, 1, 0, 3, 0, 'h055, X));
    cyc(OP_CONT, 0,     0, 0, 8'h01, 0, ex(0, 1, 1, 1, 1, 0, 3, 0, 'h056, X));

    for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(posedge clock);
    @(posedge clock);
    if (q_exp.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q_exp.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
